// File: rtl/ppu_run_ctrl_pkg.sv
// Shared definitions for the PPU run-control sequencer: FSM state encodings,
// run-mode codes and a mode normalisation helper.
package ppu_run_ctrl_pkg;

  // FSM state encodings
  localparam logic [2:0] StHold     = 3'd0;
  localparam logic [2:0] StIdle     = 3'd1;
  localparam logic [2:0] StRun      = 3'd2;
  localparam logic [2:0] StStepWait = 3'd3;
  localparam logic [2:0] StDone     = 3'd4;

  // Run-mode codes as presented on the mode input
  localparam logic [1:0] MODE_FREE  = 2'd0;
  localparam logic [1:0] MODE_STEP  = 2'd1;
  localparam logic [1:0] MODE_COUNT = 2'd2;

  // The reserved code 3 behaves exactly like a free run.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return ((m == MODE_STEP) || (m == MODE_COUNT)) ? m : MODE_FREE;
  endfunction

endpackage

// File: rtl/ppu_sat_counter.sv
// Up-counter with synchronous clear, count enable and saturation at all-ones.
// Used both for the post-reset hold counter and for the executed-cycle count.
module ppu_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  // Clear wins over enable; the count sticks once it reaches all-ones.
  always_ff @(posedge clk) begin
    if (clr) begin
      count_q <= '0;
    end else if (en && (count_q != '1)) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/ppu_run_ctrl.sv
// Run-control sequencer for the PPU core. Stretches the core reset after the
// system reset, then gates the core clock-enable for free, single-step or
// budgeted runs, stopping on halt, budget, timeout or an external abort.
// All outputs come straight from registers.
module ppu_run_ctrl
  import ppu_run_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES = 2,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned MAX_CYCLES = 11
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] n_cycles,
  input  logic             step_req,
  input  logic             halt_in,
  input  logic             stop,
  output logic             core_rst,
  output logic             core_en,
  output logic [CNT_W-1:0] cycle_count,
  output logic             done,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] RstCyc = CNT_W'(RST_CYCLES);
  localparam logic [CNT_W-1:0] MaxCyc = CNT_W'(MAX_CYCLES);
  localparam logic             TmoOn  = (MAX_CYCLES != 0);

  logic [2:0]       state_q, state_d;
  logic             core_rst_q, core_rst_d;
  logic             core_en_q, core_en_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic             step_prev_q;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] budget_q, budget_d;

  logic             launch;
  logic             step_rise;
  logic             hold_en;
  logic [CNT_W-1:0] hold_count;
  logic [CNT_W-1:0] cycle_next;
  logic             hit_budget;
  logic             hit_max;

  // Counts Reset=0 edges spent in HOLD; stops once the stretch is complete.
  assign hold_en = (state_q == StHold) && (hold_count != RstCyc);

  ppu_sat_counter #(
    .W (CNT_W)
  ) u_hold_cnt (
    .clk   (clk),
    .clr   (Reset),
    .en    (hold_en),
    .count (hold_count)
  );

  // Every edge with the core enabled is an executed cycle.
  ppu_sat_counter #(
    .W (CNT_W)
  ) u_cycle_cnt (
    .clk   (clk),
    .clr   (Reset | launch),
    .en    (core_en_q),
    .count (cycle_count)
  );

  // Exit conditions look at the count as it will be after this edge.
  assign cycle_next = (cycle_count == '1) ? cycle_count : cycle_count + CNT_W'(1);
  assign hit_budget = (mode_q == MODE_COUNT) && (cycle_next == budget_q);
  assign hit_max    = TmoOn && (cycle_next == MaxCyc);
  assign step_rise  = step_req & ~step_prev_q;

  // Next-state and registered-output decode, exit priority stop > halt/budget > timeout.
  always_comb begin
    state_d    = state_q;
    core_rst_d = 1'b0;
    core_en_d  = 1'b0;
    done_d     = done_q;
    timeout_d  = timeout_q;
    mode_d     = mode_q;
    budget_d   = budget_q;
    launch     = 1'b0;
    case (state_q)
      StHold: begin
        if (hold_count == RstCyc) begin
          state_d = StIdle;
        end else begin
          core_rst_d = 1'b1;
        end
      end
      StIdle, StDone: begin
        if (stop) begin
          state_d = StIdle;
          done_d  = 1'b0;
        end else if (start) begin
          launch    = 1'b1;
          mode_d    = norm_mode(mode);
          budget_d  = n_cycles;
          done_d    = 1'b0;
          timeout_d = 1'b0;
          if (mode_d == MODE_STEP) begin
            state_d = StStepWait;
          end else if ((mode_d == MODE_COUNT) && (n_cycles == '0)) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d   = StRun;
            core_en_d = 1'b1;
          end
        end
      end
      StRun, StStepWait: begin
        if (core_en_q) begin
          // An enabled cycle is finishing on this edge.
          if (stop) begin
            state_d = StIdle;
          end else if (halt_in || hit_budget) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else if (hit_max) begin
            state_d   = StDone;
            done_d    = 1'b1;
            timeout_d = 1'b1;
          end else begin
            core_en_d = (state_q == StRun);
          end
        end else if (stop) begin
          state_d = StIdle;
        end else begin
          core_en_d = step_rise;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; Reset overrides everything.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q     <= StHold;
      core_rst_q  <= 1'b1;
      core_en_q   <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      step_prev_q <= 1'b0;
      mode_q      <= MODE_FREE;
      budget_q    <= '0;
    end else begin
      state_q     <= state_d;
      core_rst_q  <= core_rst_d;
      core_en_q   <= core_en_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      step_prev_q <= step_req;
      mode_q      <= mode_d;
      budget_q    <= budget_d;
    end
  end

  assign core_rst = core_rst_q;
  assign core_en  = core_en_q;
  assign done     = done_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_ppu_run_ctrl.sv
// Randomised bench for ppu_run_ctrl. Each run is predicted as a whole from
// its scenario (mode, budget, halt/stop positions, step pattern) and the
// observed enabled cycles, count and flags are compared with that prediction.
module tb_ppu_run_ctrl;

  localparam int unsigned CNT_W      = 16;
  localparam int unsigned RST_CYCLES = 2;
  localparam int unsigned MAX_CYCLES = 11;

  logic             clk = 1'b0;
  logic             Reset;
  logic             start;
  logic [1:0]       mode;
  logic [CNT_W-1:0] n_cycles;
  logic             step_req;
  logic             halt_in;
  logic             stop;
  logic             core_rst;
  logic             core_en;
  logic [CNT_W-1:0] cycle_count;
  logic             done;
  logic             timeout;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ppu_run_ctrl #(
    .RST_CYCLES (RST_CYCLES),
    .CNT_W      (CNT_W),
    .MAX_CYCLES (MAX_CYCLES)
  ) dut (
    .clk         (clk),
    .Reset       (Reset),
    .start       (start),
    .mode        (mode),
    .n_cycles    (n_cycles),
    .step_req    (step_req),
    .halt_in     (halt_in),
    .stop        (stop),
    .core_rst    (core_rst),
    .core_en     (core_en),
    .cycle_count (cycle_count),
    .done        (done),
    .timeout     (timeout)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Whole-run outcome: the first event index wins, ties broken stop > halt/budget > timeout.
  // A step run that runs out of step edges first just sits waiting.
  function automatic void model(input int md, input int n, input int halt_at, input int stop_at,
                                input int rises, output int cnt, output int d, output int t);
    bit step_md  = (md == 1);
    bit count_md = (md == 2);
    int ev;
    if (count_md && n == 0) begin
      cnt = 0; d = 1; t = 0;
      return;
    end
    ev = (MAX_CYCLES != 0) ? int'(MAX_CYCLES) : (1 << 30);
    if (halt_at > 0 && halt_at < ev) ev = halt_at;
    if (stop_at > 0 && stop_at < ev) ev = stop_at;
    if (count_md && n < ev) ev = n;
    if (step_md && rises < ev) begin
      cnt = rises; d = 0; t = 0;
    end else begin
      cnt = ev;
      if (stop_at == ev) begin
        d = 0; t = 0;
      end else if (halt_at == ev || (count_md && n == ev)) begin
        d = 1; t = 0;
      end else begin
        d = 1; t = 1;
      end
    end
  endfunction

  // Release reset with start held high (must be ignored) and watch the reset stretch.
  task automatic release_hold();
    Reset = 1'b0;
    start = 1'b1;
    mode  = 2'd0;
    for (int i = 0; i <= int'(RST_CYCLES); i++) begin
      @(negedge clk);
      check_eq("hold_core_rst", core_rst, (i < int'(RST_CYCLES)) ? 1 : 0);
      check_eq("hold_core_en", core_en, 0);
    end
    start = 1'b0;
    @(negedge clk);
    check_eq("idle_core_en", core_en, 0);
    check_eq("idle_core_rst", core_rst, 0);
    check_eq("idle_done", done, 0);
  endtask

  task automatic do_reset(input int ncyc);
    @(negedge clk);
    Reset = 1'b1; start = 1'b0; stop = 1'b0; halt_in = 1'b0; step_req = 1'b0;
    repeat (ncyc) @(negedge clk);
    check_eq("rst_core_rst", core_rst, 1);
    check_eq("rst_core_en", core_en, 0);
    check_eq("rst_count", cycle_count, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_timeout", timeout, 0);
    release_hold();
  endtask

  task automatic run_scenario(input string tag, input int md, input int n, input int halt_at,
                              input int stop_at, input logic [63:0] pat, input int plen);
    bit   is_step = (md == 1);
    int   rises   = 0;
    logic prev    = 1'b0;
    int   exp_cnt, exp_done, exp_tmo;
    int   seen    = 0;
    int   rst_bad = 0;
    bit   ended   = 1'b0;
    for (int i = 0; i < plen; i++) begin
      if (pat[i] && !prev) rises++;
      prev = pat[i];
    end
    model(md, n, halt_at, stop_at, rises, exp_cnt, exp_done, exp_tmo);

    @(negedge clk);
    start = 1'b1; mode = md[1:0]; n_cycles = n[CNT_W-1:0];
    step_req = 1'b0; halt_in = 1'b0; stop = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      start = 1'b0; halt_in = 1'b0; stop = 1'b0;
      if (core_rst) rst_bad++;
      if (is_step) begin
        if (c >= plen + 3) begin
          ended = 1'b1;
          break;
        end
        step_req = (c < plen) ? pat[c] : 1'b0;
      end else if (!core_en) begin
        ended = 1'b1;
        break;
      end
      if (core_en) begin
        seen++;
        check_eq({tag, ":live_count"}, cycle_count, seen - 1);
        halt_in = (seen == halt_at);
        stop    = (seen == stop_at);
        start   = ($urandom_range(0, 3) == 0);
      end else if (is_step) begin
        halt_in = ($urandom_range(0, 2) == 0);
      end
    end
    step_req = 1'b0; halt_in = 1'b0; start = 1'b0;
    check_eq({tag, ":run_bounded"}, ended, 1);
    check_eq({tag, ":enabled_cycles"}, seen, exp_cnt);
    check_eq({tag, ":cycle_count"}, cycle_count, exp_cnt);
    check_eq({tag, ":done"}, done, exp_done);
    check_eq({tag, ":timeout"}, timeout, exp_tmo);
    check_eq({tag, ":core_en_off"}, core_en, 0);
    check_eq({tag, ":core_rst_low"}, rst_bad, 0);

    if (exp_done == 0 || $urandom_range(0, 1) == 1) begin
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      check_eq({tag, ":stop_done"}, done, 0);
      check_eq({tag, ":stop_count"}, cycle_count, exp_cnt);
      check_eq({tag, ":stop_timeout"}, timeout, exp_tmo);
      check_eq({tag, ":stop_core_en"}, core_en, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] pat;
    int          seen;
    Reset = 1'b1; start = 1'b0; mode = 2'd0; n_cycles = '0;
    step_req = 1'b0; halt_in = 1'b0; stop = 1'b0;

    do_reset(2);

    run_scenario("free_timeout", 0, 0, 0, 0, 64'd0, 0);
    run_scenario("count5", 2, 5, 0, 0, 64'd0, 0);
    run_scenario("count0", 2, 0, 0, 0, 64'd0, 0);
    run_scenario("halt4", 0, 0, 4, 0, 64'd0, 0);
    run_scenario("halt11", 0, 0, 11, 0, 64'd0, 0);
    pat = 64'b010010010111111;
    run_scenario("step_held_pulses", 1, 0, 0, 0, pat, 15);
    run_scenario("stop6", 0, 0, 0, 6, 64'd0, 0);
    run_scenario("mode3_free", 3, 3, 0, 0, 64'd0, 0);

    // Reset during the third enabled cycle of a free run.
    @(negedge clk);
    start = 1'b1; mode = 2'd0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (core_en) seen++;
      if (seen == 3) break;
    end
    check_eq("midrun_reached_3", seen, 3);
    Reset = 1'b1;
    @(negedge clk);
    check_eq("midrun_rst_core_en", core_en, 0);
    check_eq("midrun_rst_core_rst", core_rst, 1);
    check_eq("midrun_rst_count", cycle_count, 0);
    check_eq("midrun_rst_done", done, 0);
    release_hold();

    for (int it = 0; it < 40; it++) begin
      int md, n, h, s, plen;
      md   = $urandom_range(0, 3);
      n    = $urandom_range(0, 14);
      h    = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 14) : 0;
      s    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 14) : 0;
      pat  = {$urandom, $urandom};
      plen = $urandom_range(4, 24);
      run_scenario($sformatf("rand%0d", it), md, n, h, s, pat, plen);
      if ($urandom_range(0, 9) == 0) do_reset($urandom_range(1, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
